// File: rtl/md5_pipe_ctrl.sv
// rtl/md5_pipe_ctrl.sv - sequencer, valid/tag tracking and digest finalisation for an unrolled MD5 pipeline
module md5_pipe_ctrl #(
    parameter int LATENCY = 128,
    parameter int TAG_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               flush,
    input  logic [127:0]       target,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [511:0]       s_data,
    input  logic [TAG_W-1:0]   s_tag,
    output logic               pipe_en,
    output logic [31:0]        pipe_a,
    output logic [31:0]        pipe_b,
    output logic [31:0]        pipe_c,
    output logic [31:0]        pipe_d,
    output logic [511:0]       pipe_m,
    input  logic [31:0]        pipe_a_out,
    input  logic [31:0]        pipe_b_out,
    input  logic [31:0]        pipe_c_out,
    input  logic [31:0]        pipe_d_out,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [TAG_W-1:0]   r_tag,
    output logic [127:0]       r_digest,
    output logic               r_match,
    output logic               busy,
    output logic               done,
    output logic [31:0]        hash_count,
    output logic [15:0]        match_count
);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               done_d, clr_cnt;
    logic [LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [CNT_W-1:0]   in_flight_q;
    logic [511:0]       pipe_m_q;
    logic               r_valid_q, r_match_q, done_q;
    logic [TAG_W-1:0]   r_tag_q;
    logic [127:0]       r_digest_q;
    logic [31:0]        hash_count_q;
    logic [15:0]        match_count_q;
    logic               accept, capture, match_now;
    logic [127:0]       digest_sum;

    assign pipe_en    = !(r_valid_q && !r_ready);
    assign s_ready    = (state_q == RUN) && pipe_en;
    assign accept     = s_ready && s_valid;
    assign capture    = pipe_en && vld_q[LATENCY-1];
    assign digest_sum = {pipe_d_out + IV_D, pipe_c_out + IV_C, pipe_b_out + IV_B, pipe_a_out + IV_A};
    assign match_now  = (digest_sum == target);

    assign pipe_a      = IV_A;
    assign pipe_b      = IV_B;
    assign pipe_c      = IV_C;
    assign pipe_d      = IV_D;
    assign pipe_m      = pipe_m_q;
    assign r_valid     = r_valid_q;
    assign r_tag       = r_tag_q;
    assign r_digest    = r_digest_q;
    assign r_match     = r_match_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hash_count  = hash_count_q;
    assign match_count = match_count_q;

    // Run-state sequencing: start only from IDLE, flush only from RUN, drain until empty.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        clr_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clr_cnt = 1'b1;
                end
            end
            RUN: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (in_flight_q == '0 && !r_valid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and the registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Valid/tag shadow of the pipeline plus the stage-0 message register; all hold on stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q    <= '0;
            pipe_m_q <= '0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else if (pipe_en) begin
            vld_q    <= {vld_q[LATENCY-2:0], accept};
            pipe_m_q <= accept ? s_data : '0;
            tag_q[0] <= s_tag;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Count of blocks between accept and capture, used to know when a drain is complete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_flight_q <= '0;
        end else if (accept && !capture) begin
            in_flight_q <= in_flight_q + CNT_W'(1);
        end else if (capture && !accept) begin
            in_flight_q <= in_flight_q - CNT_W'(1);
        end
    end

    // Result register: a capture overwrites a consumed result so results can stream every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_q  <= 1'b0;
            r_tag_q    <= '0;
            r_digest_q <= '0;
            r_match_q  <= 1'b0;
        end else if (capture) begin
            r_valid_q  <= 1'b1;
            r_tag_q    <= tag_q[LATENCY-1];
            r_digest_q <= digest_sum;
            r_match_q  <= match_now;
        end else if (r_ready) begin
            r_valid_q  <= 1'b0;
        end
    end

    // Statistics: cleared on start, hash count wraps, match count saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hash_count_q  <= '0;
            match_count_q <= '0;
        end else if (clr_cnt) begin
            hash_count_q  <= '0;
            match_count_q <= '0;
        end else if (capture) begin
            hash_count_q <= hash_count_q + 32'd1;
            if (match_now && match_count_q != 16'hFFFF) match_count_q <= match_count_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_md5_pipe_ctrl.sv
// tb/tb_md5_pipe_ctrl.sv - self-checking bench with an MD5 pipeline stand-in and a scoreboard
module tb_md5_pipe_ctrl;
    localparam int LAT = 128;
    localparam int TW  = 16;
    localparam logic [127:0] IV_ALL    = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] EMPTY_DIG = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [511:0] EMPTY_BLK = 512'h80;
    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    localparam int MD5_S [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    logic           clk = 1'b0;
    logic           reset_n, start, flush, s_valid, r_ready;
    logic [127:0]   tgt;
    logic [511:0]   s_data;
    logic [TW-1:0]  s_tag;
    logic           s_ready, pipe_en, r_valid, r_match, busy, done;
    logic [31:0]    pipe_a, pipe_b, pipe_c, pipe_d;
    logic [31:0]    pipe_a_out, pipe_b_out, pipe_c_out, pipe_d_out;
    logic [511:0]   pipe_m;
    logic [TW-1:0]  r_tag;
    logic [127:0]   r_digest;
    logic [31:0]    hash_count;
    logic [15:0]    match_count;

    always #5 clk = ~clk;

    md5_pipe_ctrl #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .target(tgt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
        .pipe_en(pipe_en), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
        .pipe_m(pipe_m), .pipe_a_out(pipe_a_out), .pipe_b_out(pipe_b_out),
        .pipe_c_out(pipe_c_out), .pipe_d_out(pipe_d_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_tag(r_tag), .r_digest(r_digest), .r_match(r_match),
        .busy(busy), .done(done), .hash_count(hash_count), .match_count(match_count));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // MD5 compression rounds without the final IV addition.
    function automatic logic [127:0] md5_rounds(input logic [511:0] m, input logic [127:0] iv);
        logic [31:0] a, b, c, d, f;
        int g, s;
        a = iv[31:0]; b = iv[63:32]; c = iv[95:64]; d = iv[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            f = f + a + MD5_K[i] + m[32*g +: 32];
            s = MD5_S[(i / 16) * 4 + (i % 4)];
            a = d; d = c; c = b;
            b = b + ((f << s) | (f >> (32 - s)));
        end
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] md5_digest(input logic [511:0] m);
        logic [127:0] r;
        r = md5_rounds(m, IV_ALL);
        for (int w = 0; w < 4; w++) r[32*w +: 32] = r[32*w +: 32] + IV_ALL[32*w +: 32];
        return r;
    endfunction

    // Stand-in for the 64 operation units: a LAT-1 deep enabled delay line behind the pipe_m register.
    logic [127:0] stg [LAT-1];
    always @(posedge clk) begin
        if (pipe_en) begin
            for (int i = LAT - 2; i > 0; i--) stg[i] <= stg[i-1];
            stg[0] <= md5_rounds(pipe_m, {pipe_d, pipe_c, pipe_b, pipe_a});
        end
    end
    assign {pipe_d_out, pipe_c_out, pipe_b_out, pipe_a_out} = stg[LAT-2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [TW-1:0] tag; logic [127:0] dig; } exp_t;
    exp_t         q[$];
    int           n_res, exp_match, acc_cyc, rv_rise_cyc, first_res_cyc, last_res_cyc;
    logic         prev_rv;
    logic [TW-1:0] last_tag;
    logic [127:0] last_dig;
    logic         last_match;

    // Scoreboard: every accepted block must come back once, in order, with the right digest and match.
    initial begin
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (s_valid && s_ready) begin
                    q.push_back('{tag: s_tag, dig: md5_digest(s_data)});
                    acc_cyc = cyc;
                end
                if (r_valid && !prev_rv) rv_rise_cyc = cyc;
                if (r_valid && r_ready) begin
                    chk("result_expected", 128'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        exp_t e;
                        e = q.pop_front();
                        chk("r_tag", r_tag, e.tag);
                        chk("r_digest", r_digest, e.dig);
                        chk("r_match", r_match, e.dig == tgt);
                        if (e.dig == tgt) exp_match++;
                    end
                    n_res++;
                    if (n_res == 1) first_res_cyc = cyc;
                    last_res_cyc = cyc;
                    last_tag = r_tag; last_dig = r_digest; last_match = r_match;
                end
                prev_rv = r_valid;
            end else begin
                prev_rv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        n_res = 0; exp_match = 0; first_res_cyc = -1; last_res_cyc = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int w = 0; w < 16; w++) b[32*w +: 32] = $urandom;
        return b;
    endfunction

    task automatic send(input logic [TW-1:0] tag, input logic [511:0] data, input bit must_fast);
        int tries;
        logic acc;
        tries = 0;
        s_valid = 1'b1; s_data = data; s_tag = tag;
        forever begin
            @(negedge clk);
            acc = s_ready;
            tick();
            if (acc) break;
            tries++;
            if (tries > 3000) begin
                chk("send_timeout", 128'(tries), 0);
                break;
            end
        end
        if (must_fast) chk("s_ready_stream", 128'(tries), 0);
        s_valid = 1'b0; s_data = '0;
    endtask

    task automatic drain(output int done_cyc);
        int dn;
        flush = 1'b1; tick(); flush = 1'b0;
        @(negedge clk);
        chk("flush_s_ready", s_ready, 0);
        chk("flush_busy", busy, 1);
        done_cyc = -1;
        for (int k = 0; k < 4000; k++) begin
            if (done) begin done_cyc = cyc; break; end
            @(negedge clk);
        end
        chk("done_seen", 128'(done_cyc >= 0), 1);
        chk("busy_at_done", busy, 0);
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("done_single", 128'(dn), 0);
    endtask

    task automatic wait_results(input int n);
        for (int k = 0; k < 3000 && n_res < n; k++) @(negedge clk);
        chk("wait_results", 128'(n_res), 128'(n));
    endtask

    initial begin
        int dc, t0;
        logic [TW-1:0]  held_tag;
        logic [127:0]   held_dig;
        logic           stop;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; s_valid = 1'b0; r_ready = 1'b1;
        tgt = '0; s_data = '0; s_tag = '0;
        clear_stats();

        // Reset state.
        tick(); @(negedge clk);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_tag", r_tag, 0);
        chk("rst_r_digest", r_digest, 0);
        chk("rst_r_match", r_match, 0);
        chk("rst_hash", hash_count, 0);
        chk("rst_match_cnt", match_count, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("iv_out", {pipe_d, pipe_c, pipe_b, pipe_a}, IV_ALL);
        tick(); reset_n = 1'b1; tick();

        // Flush in IDLE is ignored.
        flush = 1'b1; tick(); flush = 1'b0;
        @(negedge clk);
        chk("flush_in_idle", busy, 0);
        tick();

        // Single empty-string block.
        tgt = EMPTY_DIG; clear_stats();
        pulse_start();
        send(16'h0001, EMPTY_BLK, 1);
        wait_results(1);
        chk("latency", 128'(rv_rise_cyc - acc_cyc), LAT + 1);
        chk("t1_tag", last_tag, 16'h0001);
        chk("t1_digest", last_dig, EMPTY_DIG);
        chk("t1_match", last_match, 1);
        drain(dc);
        chk("t1_hash_count", hash_count, 1);
        chk("t1_match_count", match_count, 1);

        // 200 back-to-back blocks, one empty-string block among them.
        clear_stats();
        pulse_start();
        for (int t = 0; t < 200; t++) send(TW'(t), (t == 7) ? EMPTY_BLK : rand_blk(), 1);
        drain(dc);
        chk("t2_results", 128'(n_res), 200);
        chk("t2_consecutive", 128'(last_res_cyc - first_res_cyc + 1), 200);
        chk("t2_hash_count", hash_count, 200);
        chk("t2_match_count", match_count, 128'(exp_match));
        chk("t2_exp_match", 128'(exp_match), 1);

        // Same stream with a 10-cycle consumer stall mid-stream.
        clear_stats();
        pulse_start();
        fork
            for (int t = 0; t < 200; t++) send(TW'(t), rand_blk(), 0);
            begin
                repeat (150) tick();
                r_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (i == 0) begin held_tag = r_tag; held_dig = r_digest; end
                    chk("stall_pipe_en", pipe_en, 0);
                    chk("stall_s_ready", s_ready, 0);
                    chk("stall_r_valid", r_valid, 1);
                    chk("stall_r_tag", r_tag, held_tag);
                    chk("stall_r_digest", r_digest, held_dig);
                end
                tick();
                r_ready = 1'b1;
                @(negedge clk);
                chk("unstall_pipe_en", pipe_en, 1);
            end
        join
        drain(dc);
        chk("t3_results", 128'(n_res), 200);
        chk("t3_hash_count", hash_count, 200);

        // Flush after 5 accepts.
        clear_stats();
        pulse_start();
        for (int t = 0; t < 5; t++) send(TW'(16'h100 + t), rand_blk(), 1);
        drain(dc);
        chk("t4_results", 128'(n_res), 5);
        chk("t4_done_after_consume", 128'(dc > last_res_cyc), 1);

        // Reset with 50 blocks in flight.
        clear_stats();
        pulse_start();
        for (int t = 0; t < 50; t++) send(TW'(16'h200 + t), rand_blk(), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_hash", hash_count, 0);
        chk("mid_rst_match", match_count, 0);
        q.delete();
        tick(); reset_n = 1'b1; tick();
        clear_stats();
        pulse_start();
        for (int t = 0; t < 3; t++) send(TW'(16'h5000 + t), rand_blk(), 1);
        drain(dc);
        chk("t5_results", 128'(n_res), 3);
        chk("t5_hash_count", hash_count, 3);

        // Start in RUN is ignored (counters not cleared, still running).
        clear_stats();
        pulse_start();
        send(16'h0300, rand_blk(), 1);
        send(16'h0301, rand_blk(), 1);
        wait_results(2);
        tick();
        pulse_start();
        @(negedge clk);
        chk("start_in_run_busy", busy, 1);
        chk("start_in_run_s_ready", s_ready, 1);
        chk("start_in_run_hash", hash_count, 2);
        tick();
        drain(dc);

        // Random gaps on input and random backpressure on output.
        clear_stats();
        tgt = EMPTY_DIG;
        stop = 1'b0;
        pulse_start();
        fork
            begin
                for (int t = 0; t < 60; t++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(TW'($urandom), ($urandom_range(0, 9) == 0) ? EMPTY_BLK : rand_blk(), 0);
                end
                drain(dc);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    r_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                r_ready = 1'b1;
            end
        join
        chk("t7_results", 128'(n_res), 60);
        chk("t7_hash_count", hash_count, 60);
        chk("t7_match_count", match_count, 128'(exp_match));
        chk("t7_queue_empty", 128'(q.size()), 0);

        t0 = cyc;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
